// File: rtl/maj_sub_pkg.sv
// Shared types and constants for the bit-serial majority-gate subtractor.
package maj_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/maj3.sv
// Three-input, one-bit majority gate.
module maj3 (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic m
);

   assign m = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_maj_subtractor.sv
// Bit-serial a - b built from majority gates only, one bit per clock, LSB first.
// Optional signed overflow output enabled by defining SERIAL_MAJ_SUB_OVERFLOW_EN.
module serial_maj_subtractor
   import maj_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_MAJ_SUB_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic x, y, c;
   logic m_xyc, m_xy_nc, sum_bit;

   // Subtraction as a + ~b + 1: operand b is inverted bit by bit, carry starts at 1.
   assign x = a_sh[0];
   assign y = ~b_sh[0];
   assign c = carry;

   maj3 u_carry (.x(x),       .y(y), .z(c),       .m(m_xyc));
   maj3 u_alt   (.x(x),       .y(y), .z(~c),      .m(m_xy_nc));
   maj3 u_sum   (.x(~m_xyc),  .y(c), .z(m_xy_nc), .m(sum_bit));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef SERIAL_MAJ_SUB_OVERFLOW_EN
         overflow   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= 1'b1;
                  cnt   <= '0;
                  diff  <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               diff  <= {sum_bit, diff[WIDTH-1:1]};
               carry <= m_xyc;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  borrow_out <= ~m_xyc;
`ifdef SERIAL_MAJ_SUB_OVERFLOW_EN
                  // Carry into the MSB is the held carry; carry out is this step's majority.
                  overflow   <= c ^ m_xyc;
`endif
                  state      <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_maj_subtractor.sv
// Scoreboard bench: stimulus pushes arithmetic expectations, a monitor checks each done pulse.
module tb_serial_maj_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_MAJ_SUB_OVERFLOW_EN
   logic         overflow;
`endif

   serial_maj_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_MAJ_SUB_OVERFLOW_EN
      ,
      .overflow   (overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      int unsigned  cyc;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Reference: plain modular, unsigned and signed arithmetic; done due W+1 edges after accept.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input int unsigned acc);
      exp_t e;
      int   sd;
      e.d   = W'(x - y);
      e.br  = (x < y);
      sd    = int'($signed(x)) - int'($signed(y));
      e.ov  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
      e.cyc = acc + W + 1;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
         end else begin
            e = q.pop_front();
            check("diff", diff, e.d);
            check("borrow_out", borrow_out, e.br);
            check("done_cycle", cyc, e.cyc);
            check("busy_at_done", busy, 0);
`ifdef SERIAL_MAJ_SUB_OVERFLOW_EN
            check("overflow", overflow, e.ov);
`endif
            $display("op: diff=%0h borrow=%0b cycle=%0d", diff, borrow_out, cyc);
         end
      end
   end

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit noise,
                        input int restart_at, input logic [W-1:0] rx, input logic [W-1:0] ry);
      int unsigned acc;
      @(negedge clk);
      start = 1'b1;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      acc = cyc;
      q.push_back(model(x, y, acc));
      for (int k = 1; k <= W + 1; k++) begin
         @(negedge clk);
         if (k == restart_at) begin
            start = 1'b1;
            a = rx;
            b = ry;
         end else if (noise) begin
            start = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      check("done_seen", q.size(), 0);
      q.delete();
   endtask

   initial begin
      logic [W-1:0] dir_a[7];
      logic [W-1:0] dir_b[7];
      int lows;
      logic [W-1:0] hx, hy;
      dir_a = '{8'h05, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h09, 8'h03};
      dir_b = '{8'h03, 8'h00, 8'h01, 8'h01, 8'h01, 8'h04, 8'h05};

      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_borrow", borrow_out, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) do_op(dir_a[i], dir_b[i], 1'b0, -1, '0, '0);

      // Second start during the operation must be ignored.
      do_op(8'h10, 8'h01, 1'b0, 2, 8'h00, 8'hFF);

      // Abort mid-operation with an asynchronous reset.
      @(negedge clk);
      start = 1'b1;
      a = 8'h55;
      b = 8'h00;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_borrow", borrow_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      do_op(8'h09, 8'h04, 1'b0, -1, '0, '0);

      for (int i = 0; i < 20; i++) do_op(W'($urandom), W'($urandom), 1'b1, -1, '0, '0);

      // Start held high: back-to-back operations every W+2 cycles.
      hx = W'($urandom);
      hy = W'($urandom);
      lows = 0;
      @(negedge clk);
      a = hx;
      b = hy;
      start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (i % (W + 2) == 0) q.push_back(model(hx, hy, cyc));
         @(negedge clk);
         if (!busy) lows++;
      end
      start = 1'b0;
      check("busy_low_cycles", lows, 3);
      #1;
      check("held_all_done", q.size(), 0);
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
